// File: rtl/fan_pkg.sv
// Shared constants and FSM state type for the LED fan blocks.
package fan_pkg;

  localparam int unsigned DEF_STEPS  = 360;
  localparam int unsigned DEF_LED_W  = 16;
  localparam int unsigned DEF_ADDR_W = 9;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fan_state_e;

endpackage

// File: rtl/fan_column_sched_if.sv
// Pattern-memory fetch handshake: scheduler is master, memory is slave.
interface fan_column_sched_if #(
  parameter int unsigned ADDR_W = fan_pkg::DEF_ADDR_W,
  parameter int unsigned LED_W  = fan_pkg::DEF_LED_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [LED_W-1:0]  mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );

endinterface

// File: rtl/fan_step_sync.sv
// Two-flop synchronizer for the asynchronous fan step input plus rising-edge detect.
module fan_step_sync (
  input  logic clk,
  input  logic rst,
  input  logic fanclk,
  output logic step
);

  // [0],[1] synchronize; [2] holds the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], fanclk};
    end
  end

  assign step = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/fan_column_sched.sv
// Column scheduler: tracks blade angle from fanclk and fetches one LED column per step.
// Optional FAN_ROTATE_EN adds a per-revolution address offset so the image rotates.
module fan_column_sched
  import fan_pkg::*;
#(
  parameter int unsigned STEPS  = DEF_STEPS,
  parameter int unsigned LED_W  = DEF_LED_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fanclk,
  input  logic               enable,
  fan_column_sched_if.master mem,
  output logic [LED_W-1:0]   led,
  output logic               frame_start,
  output logic               overrun
);

  localparam logic [ADDR_W-1:0] LAST_ANGLE = ADDR_W'(STEPS - 1);

  logic              step;
  logic              wrap;
  fan_state_e        state_q, state_d;
  logic [ADDR_W-1:0] angle_q, angle_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fetch_addr;
  logic [LED_W-1:0]  led_q, led_d;
  logic              pend_q, pend_d;
  logic              overrun_q, overrun_d;
  logic              frame_q;

  fan_step_sync u_step_sync (
    .clk    (clk),
    .rst    (rst),
    .fanclk (fanclk),
    .step   (step)
  );

  assign wrap = step && (angle_q == LAST_ANGLE);

  always_comb begin
    angle_d = angle_q;
    if (step) begin
      angle_d = wrap ? '0 : angle_q + 1'b1;
    end
  end

`ifdef FAN_ROTATE_EN
  localparam logic [ADDR_W:0] STEPS_X = (ADDR_W+1)'(STEPS);

  logic [ADDR_W-1:0] offset_q, offset_d;

  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= STEPS_X) begin
      sum = sum - STEPS_X;
    end
    return sum[ADDR_W-1:0];
  endfunction

  // Offset moves on the wrap step itself so angle and offset take their new values together
  assign offset_d   = wrap ? mod_add(offset_q, ADDR_W'(1)) : offset_q;
  assign fetch_addr = mod_add(angle_d, offset_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end
`else
  assign fetch_addr = angle_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    led_d     = led_q;
    pend_d    = pend_q;
    overrun_d = overrun_q;
    if (!enable) begin
      led_d = '0;
    end
    case (state_q)
      IDLE: begin
        // Address tracks the angle while idle and freezes once a fetch is launched
        addr_d = fetch_addr;
        pend_d = 1'b0;
        if (enable && (step || pend_q)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (step) begin
          overrun_d = 1'b1;
          if (enable) begin
            pend_d = 1'b1;
          end
        end
        if (mem.mem_ack) begin
          state_d = IDLE;
          if (enable) begin
            led_d = mem.mem_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      angle_q   <= '0;
      addr_q    <= '0;
      led_q     <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      addr_q    <= addr_d;
      led_q     <= led_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      frame_q   <= wrap;
    end
  end

  assign mem.mem_req  = (state_q == REQ);
  assign mem.mem_addr = addr_q;
  assign led          = led_q;
  assign frame_start  = frame_q;
  assign overrun      = overrun_q;

endmodule
